// File: rtl/softmax_row_buffer.sv
// Row staging buffer for the softmax datapath: loads one row, tracks its max, replays it R times.
// Optional last-beat lane masking is enabled with `define SOFTMAX_ROWBUF_MASK_EN.

module softmax_rowbuf_lane #(
  parameter int FP_WIDTH = 32
) (
  input  logic [FP_WIDTH-1:0] val,
  input  logic                mask,
  output logic [FP_WIDTH-1:0] val_o,
  output logic [FP_WIDTH-1:0] key
);
  localparam logic [FP_WIDTH-1:0] NEG_INF  = FP_WIDTH'(32'hFF80_0000);
  localparam logic [FP_WIDTH-1:0] SIGN_BIT = {1'b1, {(FP_WIDTH-1){1'b0}}};

  assign val_o = mask ? NEG_INF : val;
  // Monotone unsigned key: negatives invert, positives get the top bit set.
  assign key   = val[FP_WIDTH-1] ? ~val : (val | SIGN_BIT);
endmodule

module softmax_row_buffer #(
  parameter int DataWidth = 128,
  parameter int FP_WIDTH  = 32,
  parameter int PE_NUM    = DataWidth / FP_WIDTH,
  parameter int MAX_BEATS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ext_start_i,
  input  logic [31:0]          ext_csr_i_0,
  input  logic                 ext_data_i_valid,
  output logic                 ext_data_i_ready,
  input  logic [DataWidth-1:0] ext_data_i_bits,
  output logic                 ext_data_o_valid,
  input  logic                 ext_data_o_ready,
  output logic [DataWidth-1:0] ext_data_o_bits,
  output logic [FP_WIDTH-1:0]  ext_max_o,
  output logic                 ext_last_o,
  output logic                 ext_busy_o,
  output logic                 ext_err_o
);
  localparam int PW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [15:0] MAX_N = 16'(MAX_BEATS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]          state;
  logic [PW-1:0]       wr_ptr, rd_ptr, n_last;
  logic [3:0]          pass_cnt, pass_last;
  logic [FP_WIDTH-1:0] run_max, run_key;
  logic                err_q;

  logic [DataWidth-1:0] buffer [MAX_BEATS];

  logic [PE_NUM-1:0][FP_WIDTH-1:0] lanes_in, lanes_w, lanes_key;
  logic [PE_NUM-1:0]               lane_mask;
  logic [FP_WIDTH-1:0]             beat_max, beat_key;

  logic [15:0] len;
  logic [3:0]  reps;
  logic        len_ok, start_ok, in_hs, out_hs, fill, drain;

  assign len      = ext_csr_i_0[15:0];
  assign reps     = ext_csr_i_0[19:16];
  assign len_ok   = (len != 16'd0) && (len <= MAX_N);
  assign start_ok = (state == IDLE) && ext_start_i && len_ok;
  assign fill     = (state == FILL);
  assign drain    = (state == DRAIN);
  assign in_hs    = fill && ext_data_i_valid;
  assign out_hs   = drain && ext_data_o_ready;

`ifdef SOFTMAX_ROWBUF_MASK_EN
  logic [7:0] lanes_q, lanes_raw, lanes_eff;
  logic       unused_csr;

  assign lanes_raw  = {3'b000, ext_csr_i_0[28:24]};
  assign lanes_eff  = (lanes_raw == 8'd0 || lanes_raw > 8'(PE_NUM)) ? 8'(PE_NUM) : lanes_raw;
  assign unused_csr = ^{ext_csr_i_0[31:29], ext_csr_i_0[23:20]};

  always_ff @(posedge clk_i) begin
    if (rst_i)         lanes_q <= 8'(PE_NUM);
    else if (start_ok) lanes_q <= lanes_eff;
  end

  // Only the final beat of the row carries padding lanes.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < PE_NUM; i++)
      lane_mask[i] = (wr_ptr == n_last) && (8'(i) >= lanes_q);
  end
`else
  logic unused_csr;
  assign unused_csr = ^{ext_csr_i_0[31:20]};
  assign lane_mask  = '0;
`endif

  assign lanes_in = ext_data_i_bits;

  for (genvar g = 0; g < PE_NUM; g++) begin : g_lane
    softmax_rowbuf_lane #(.FP_WIDTH(FP_WIDTH)) u_lane (
      .val   (lanes_in[g]),
      .mask  (lane_mask[g]),
      .val_o (lanes_w[g]),
      .key   (lanes_key[g])
    );
  end

  // Strict greater-than keeps the lowest lane on ties; lane 0 is never masked.
  always_comb begin
    beat_max = lanes_in[0];
    beat_key = lanes_key[0];
    for (int i = 1; i < PE_NUM; i++) begin
      if (!lane_mask[i] && lanes_key[i] > beat_key) begin
        beat_max = lanes_in[i];
        beat_key = lanes_key[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_hs) buffer[wr_ptr] <= lanes_w;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      n_last    <= '0;
      pass_cnt  <= '0;
      pass_last <= '0;
      run_max   <= '0;
      run_key   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ext_start_i) begin
            if (len_ok) begin
              n_last    <= PW'(len - 16'd1);
              pass_last <= (reps == 4'd0) ? 4'd0 : reps - 4'd1;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              pass_cnt  <= '0;
              state     <= FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (in_hs) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (wr_ptr == '0 || beat_key > run_key) begin
              run_max <= beat_max;
              run_key <= beat_key;
            end
            if (wr_ptr == n_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (rd_ptr == n_last) begin
              rd_ptr   <= '0;
              pass_cnt <= pass_cnt + 4'd1;
              if (pass_cnt == pass_last) state <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated so the unreset buffer never leaks out of IDLE/FILL.
  assign ext_data_i_ready = fill;
  assign ext_data_o_valid = drain;
  assign ext_data_o_bits  = drain ? buffer[rd_ptr] : '0;
  assign ext_max_o        = drain ? run_max : '0;
  assign ext_last_o       = drain && (rd_ptr == n_last);
  assign ext_busy_o       = (state != IDLE);
  assign ext_err_o        = err_q;
endmodule

// File: tb/tb_softmax_row_buffer.sv
// Directed + randomized bench for softmax_row_buffer against a row-level reference model.
// Lane-mask scenario runs only when SOFTMAX_ROWBUF_MASK_EN is defined.

module tb_softmax_row_buffer;
  localparam int DW = 128, FW = 32, PE = 4, MB = 32;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, o_valid, o_ready, o_last, busy, err;
  logic [31:0]   csr;
  logic [DW-1:0] in_bits, o_bits;
  logic [FW-1:0] o_max;

  always #5 clk = ~clk;

  softmax_row_buffer #(.DataWidth(DW), .FP_WIDTH(FW), .MAX_BEATS(MB)) dut (
    .clk_i(clk), .rst_i(rst), .ext_start_i(start), .ext_csr_i_0(csr),
    .ext_data_i_valid(in_valid), .ext_data_i_ready(in_ready), .ext_data_i_bits(in_bits),
    .ext_data_o_valid(o_valid), .ext_data_o_ready(o_ready), .ext_data_o_bits(o_bits),
    .ext_max_o(o_max), .ext_last_o(o_last), .ext_busy_o(busy), .ext_err_o(err)
  );

  typedef struct packed { logic [DW-1:0] bits; logic [FW-1:0] mx; logic last; } exp_t;
  exp_t          q[$];
  logic [DW-1:0] row [MB];
  int            tests = 0, fails = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [DW-1:0] mk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] sp [8] = '{32'h0, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                            32'h7FC0_0000, 32'hFFC0_0000, 32'h3F80_0000, 32'hBF80_0000};
    return ($urandom_range(3) == 0) ? sp[$urandom_range(7)] : $urandom;
  endfunction

  task automatic rand_row(input int n);
    for (int k = 0; k < n; k++) row[k] = mk(rnd_val(), rnd_val(), rnd_val(), rnd_val());
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ovalid"}, o_valid, 0);
    check({tag, "_obits"},  o_bits,  0);
    check({tag, "_omax"},   o_max,   0);
    check({tag, "_olast"},  o_last,  0);
    check({tag, "_busy"},   busy,    0);
    check({tag, "_iready"}, in_ready, 0);
    check({tag, "_err"},    err,     0);
  endtask

  // Runs one row: builds the expected replay stream, starts, feeds and drains with
  // the given handshake probabilities (percent). abort_after>0 stops once that many
  // outputs have been consumed, leaving the DUT mid-DRAIN.
  task automatic run_row(input string tag, input int n, input int r, input int l,
                         input int p_in, input int p_out, input bit nobubble, input int abort_after);
    logic [DW-1:0] b;
    logic [DW-1:0] rexp [MB];
    logic [31:0]   m, v;
    int            leff, nin, nout, cyc, passes;
    bit            prev_fin;
    leff = PE;
`ifdef SOFTMAX_ROWBUF_MASK_EN
    if (l > 0 && l <= PE) leff = l;
`endif
    m = row[0][FW-1:0];
    for (int k = 0; k < n; k++) begin
      b = row[k];
      for (int i = 0; i < PE; i++) begin
        if (k == n-1 && i >= leff) b[i*FW +: FW] = 32'hFF80_0000;
        else begin
          v = row[k][i*FW +: FW];
          if (fkey(v) > fkey(m)) m = v;
        end
      end
      rexp[k] = b;
    end
    passes = (r == 0) ? 1 : r;
    q.delete();
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < n; k++) q.push_back('{bits: rexp[k], mx: m, last: (k == n-1)});

    @(negedge clk);
    start = 1'b1; csr = {3'b000, 5'(l), 4'b0000, 4'(r), 16'(n)};
    in_valid = 1'b1; in_bits = {$urandom, $urandom, $urandom, $urandom};
    o_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; csr = $urandom; in_valid = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_ready_rise"}, in_ready, 1);

    nin = 0; nout = 0; cyc = 0; prev_fin = 1'b0;
    while (q.size() != 0 && !(abort_after > 0 && nout >= abort_after)) begin
      if (cyc >= 4000) begin
        check({tag, "_timeout_left"}, q.size(), 0);
        break;
      end
      if (prev_fin) check({tag, "_latency"}, o_valid, 1);
      prev_fin = 1'b0;
      if (nobubble && nout > 0) check({tag, "_no_bubble"}, o_valid, 1);
      if (o_valid) begin
        check({tag, "_bits"}, o_bits, q[0].bits);
        check({tag, "_max"},  o_max,  q[0].mx);
        check({tag, "_last"}, o_last, q[0].last);
      end
      in_valid = (nin < n) && ($urandom_range(99) < p_in);
      in_bits  = in_valid ? row[nin] : {$urandom, $urandom, $urandom, $urandom};
      o_ready  = ($urandom_range(99) < p_out);
      if (in_valid && in_ready) begin
        nin++;
        if (nin == n) prev_fin = 1'b1;
      end
      if (o_valid && o_ready) begin
        void'(q.pop_front());
        nout++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (abort_after == 0) begin
      o_ready = 1'b0;
      check({tag, "_busy_fall"}, busy, 0);
      check({tag, "_valid_fall"}, o_valid, 0);
    end
  endtask

  task automatic bad_start(input string tag, input int n);
    @(negedge clk);
    start = 1'b1; csr = 32'(n) | 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err_pulse"}, err, 1);
    check({tag, "_no_busy"}, busy, 0);
    check({tag, "_no_ready"}, in_ready, 0);
    @(negedge clk);
    check({tag, "_err_drop"}, err, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; csr = '0; in_valid = 1'b0; in_bits = '0; o_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    row[0] = mk(32'h3F80_0000, 32'hC000_0000, 32'h4060_0000, 32'h0000_0000);
    row[1] = mk(32'hC0E0_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000);
    run_row("basic", 2, 1, 0, 100, 100, 1'b0, 0);

    rand_row(3);
    run_row("replay", 3, 2, 0, 100, 100, 1'b1, 0);

    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(8, 1);
      rand_row(n);
      run_row("bp", n, $urandom_range(3), $urandom_range(7), $urandom_range(100, 30),
              $urandom_range(100, 30), 1'b0, 0);
    end

    row[0] = mk(32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000);
    row[1] = mk(32'hFF80_0000, 32'hFF80_0000, 32'h8000_0000, 32'hFF80_0000);
    run_row("neg_zero", 2, 1, 0, 100, 100, 1'b0, 0);

    row[0] = mk(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000);
    run_row("pos_zero", 1, 1, 0, 100, 100, 1'b0, 0);

    rand_row(MB);
    run_row("max_len", MB, 1, 0, 80, 80, 1'b0, 0);

    bad_start("len0", 0);
    bad_start("len_over", MB + 1);

    rand_row(4);
    run_row("abort", 4, 2, 0, 100, 100, 1'b0, 3);
    rst = 1'b1; o_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    rand_row(5);
    run_row("after_reset", 5, 2, 0, 70, 70, 1'b0, 0);

`ifdef SOFTMAX_ROWBUF_MASK_EN
    row[0] = mk(32'h3F80_0000, 32'h4000_0000, 32'h4110_0000, 32'h4110_0000);
    run_row("mask", 1, 1, 2, 100, 100, 1'b0, 0);
    rand_row(3);
    run_row("mask_rand", 3, 2, 3, 60, 60, 1'b0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/softmax_row_buffer.md
# softmax_row_buffer

Parametrised row staging stage for the softmax datapath. It accepts one softmax row as a stream of PE_NUM-lane fp32 beats and stores the whole row locally. While the row is loading, it tracks the row maximum. It then replays the buffered row one or more times with the row maximum attached to every beat, so the downstream exp/normalise PEs can run their exp-sum and normalise passes without refetching the row. Both sides use full valid/ready back-pressure.

## Interface
- DataWidth, 128, beat width in bits
- FP_WIDTH, 32, lane width (IEEE-754 binary32)
- PE_NUM, DataWidth/FP_WIDTH, lanes per beat
- MAX_BEATS, 32, buffer depth in beats (maximum row length)
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- ext_start_i  in  1  start pulse, sampled only in IDLE
- ext_csr_i_0  in  32  [15:0] row length in beats N; [19:16] pass count R (0 is treated as 1); [28:24] valid lanes in the last beat (only with the macro)
- ext_data_i_valid  in  1  input beat valid
- ext_data_i_ready  out  1  input beat ready
- ext_data_i_bits  in  DataWidth  input beat, lane i = bits[i*FP_WIDTH +: FP_WIDTH]
- ext_data_o_valid  out  1  output beat valid
- ext_data_o_ready  in  1  output beat ready
- ext_data_o_bits  out  DataWidth  replayed beat
- ext_max_o  out  FP_WIDTH  row maximum, valid with ext_data_o_valid
- ext_last_o  out  1  final beat of the current pass
- ext_busy_o  out  1  high from an accepted start until the final output handshake
- ext_err_o  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, FILL, DRAIN.
- IDLE:
  - On ext_start_i with 1 ≤ N ≤ MAX_BEATS: latch N and R (plus lane count under the macro), clear the pointers and the pass counter, and go to FILL.
  - On ext_start_i with N = 0 or N > MAX_BEATS: pulse ext_err_o and stay in IDLE.
- FILL:
  - ext_data_i_ready = 1.
  - Each handshake writes the beat to buffer[wr_ptr] and increments wr_ptr.
  - The running max is updated with the lane-tree max of the beat. On the first beat, the running max is loaded directly.
  - The handshake with wr_ptr = N-1 moves the block to DRAIN.
- DRAIN:
  - ext_data_o_valid = 1, ext_data_o_bits = buffer[rd_ptr], ext_max_o = running max.
  - ext_last_o = (rd_ptr = N-1).
  - Each output handshake increments rd_ptr. On the last beat, rd_ptr wraps to 0 and the pass counter increments.
  - After pass R completes, go to IDLE.
- Ordering for max:
  - Each value is mapped to the unsigned key: sign ? ~x : x | 0x80000000. The larger key wins.
  - Consequences: -0 < +0; NaNs order by their bit pattern (a positive NaN beats +inf).
  - On a tie, the earlier value is kept.
- Out of range fields:
  - ext_start_i while busy is ignored.
  - ext_csr_i_0 is read only at an accepted start. Later changes do not affect the row in flight.
- Reset: rst_i at any cycle returns the block to IDLE. All outputs go to 0. Buffer contents become don't-care.

## Timing
- Reset values: ext_data_i_ready, ext_data_o_valid, ext_last_o, ext_busy_o, ext_err_o = 0; ext_data_o_bits = 0; ext_max_o = 0.
- Start in cycle t:
  - FILL begins at t+1 and ext_busy_o rises at t+1.
  - Input offered at t is not accepted.
  - ext_err_o for a rejected start appears at t+1.
- The final input handshake in cycle t makes the first output valid at t+1. Minimum latency through the block is N+1 cycles.
- Data hold while stalled: ext_data_o_bits, ext_max_o and ext_last_o are stable while valid & !ready.
- Throughput: one beat per cycle in both FILL and DRAIN. Back-to-back passes have no bubble.
- End of row: ext_busy_o falls in the cycle after the final output handshake. A new start is accepted in that same cycle.
- Buffer and max are flop-based. The max is registered at the input handshake, so there is no combinational path from input to output.

## Configuration
- SOFTMAX_ROWBUF_MASK_EN defined:
  - Field L = csr[28:24] gives the valid lanes in beat N-1. L = 0 or L > PE_NUM means all PE_NUM lanes are valid.
  - Lanes i ≥ L of the last beat are excluded from the max and are stored and replayed as 0xFF800000 (-inf).
- SOFTMAX_ROWBUF_MASK_EN undefined: csr[28:24] is ignored and all lanes of every beat participate.

## Test plan
- Basic row (N=2, R=1, PE_NUM=4):
  - Stimulus: beats {1.0, -2.0, 3.5, 0.0} and {-7.0, 2.0, 1.0, 3.0}.
  - Required: two output beats identical to the input; ext_max_o = 0x40600000 (3.5); ext_last_o only on beat 2; busy falls after.
- Replay (N=3, R=2):
  - Required: 6 output beats with rows repeated in order.
  - ext_last_o on output beats 3 and 6.
  - No idle cycle between passes with ready held high.
- Back-pressure:
  - Stimulus: random ext_data_i_valid and ext_data_o_ready.
  - Required: no loss or duplication; outputs stable while stalled; ext_max_o unchanged.
- Edge values:
  - Row of all -inf with one -0.0 gives max 0x80000000.
  - Row with +0 and -0 gives max 0x00000000.
  - N = MAX_BEATS is accepted.
  - N=0 and N=MAX_BEATS+1 produce an ext_err_o pulse with no busy.
- Reset mid-DRAIN:
  - rst_i asserted during DRAIN gives all outputs 0 the next cycle.
  - A new start then runs a clean row.
- With SOFTMAX_ROWBUF_MASK_EN, N=1, L=2:
  - Stimulus: input {1.0, 2.0, 9.0, 9.0}.
  - Required: output {1.0, 2.0, -inf, -inf} and max 2.0.
